branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor and resolution controller for the 5-stage RISC-V pipeline. It predicts direction and target for the fetch PC in IF from a direct-mapped branch target table with 2-bit saturating counters. It resolves the branch or jump in EX using the branch comparator result, and drives the PC redirect and the IF/ID and ID/EX flushes on a mispredict. It also keeps mispredict and resolved-branch performance counters.

## Interface
- ENTRIES, 16, table depth; power of two, ≥2. IDX = log2(ENTRIES).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_pc  in  32  fetch PC.
- if_pred_taken  out  1  predict taken for if_pc.
- if_pred_target  out  32  predicted target; 0 when if_pred_taken=0.
- ex_valid  in  1  valid instruction in EX.
- ex_branch  in  1  EX holds a conditional branch.
- ex_jump  in  1  EX holds JAL/JALR; mutually exclusive with ex_branch.
- ex_stall  in  1  EX held this cycle.
- ex_pc  in  32  PC of the EX instruction.
- ex_target  in  32  computed target.
- ex_cmp_result  in  1  branch comparator result.
- ex_pred_taken  in  1  prediction piped down with the instruction.
- ex_pred_target  in  32  predicted target piped down.
- redirect  out  1  mispredict; load redirect_pc into the PC.
- redirect_pc  out  32  corrected next PC.
- flush_if_id  out  1  squash the IF/ID register.
- flush_id_ex  out  1  squash the ID/EX register.
- mispredict_count  out  32  mispredicts since reset; wraps.
- branch_count  out  32  resolved branches and jumps since reset; wraps.

## Operation
- Entry fields: valid, tag = pc[31:IDX+2], target[31:0], jmp, ctr[1:0]. Index = pc[IDX+1:2].
- Reset state: every valid=0, ctr=2'b01, tag/target/jmp=0. Both perf counters are 0.
- Prediction: hit = valid && tag==if_pc tag. if_pred_taken = hit && (jmp || ctr[1]). if_pred_target = if_pred_taken ? target : 0.
- Resolution fires when res = ex_valid && !ex_stall && (ex_branch || ex_jump).
- actual = ex_jump || (ex_branch && ex_cmp_result).
- mis = res && ((actual != ex_pred_taken) || (actual && ex_pred_target != ex_target)).
- redirect = flush_if_id = flush_id_ex = mis.
- redirect_pc = actual ? ex_target : ex_pc + 32'd4. This sum is a modulo-2^32 add. redirect_pc is 0 when mis=0.
- Table update on res only; ex_hit is the lookup for ex_pc.
  - actual=1, ex_hit: write target and jmp. ctr = sat_inc(ctr), saturating at 2'b11.
  - actual=1, miss: allocate or replace the entry. valid=1, tag, target, jmp=ex_jump, ctr=2'b10.
  - actual=0, ex_hit: ctr = sat_dec(ctr), saturating at 2'b00. Entry stays valid.
  - actual=0, miss: no change.
- Counters: on res, branch_count increments; on mis, mispredict_count increments. Both wrap at 2^32−1 → 0.
- A stalled EX instruction resolves exactly once, in the first cycle where ex_stall=0.
- Behaviour when ex_branch and ex_jump are both 1 is undefined. The bench never drives this.

## Timing
- Prediction and redirect/flush outputs are combinational, with zero cycles of latency from their inputs.
- Table and counter updates are registered and become visible the cycle after res.
- Same-index IF read and EX update in the same cycle: IF sees the pre-update entry (read-before-write).
- rst asserted mid-operation clears all entries and counters immediately. While rst=1, all outputs except redirect_pc's combinational path from EX inputs reflect the reset state. redirect=0 whenever rst=1.
- Throughput is one resolution per cycle, with no internal stalls.

## Test plan
- Reset, then if_pc=0x100 → if_pred_taken=0, if_pred_target=0, both counters 0.
- Cold taken branch: ex_pc=0x100, ex_target=0x80, cmp=1, pred_taken=0 → redirect=1, redirect_pc=0x80, both flushes 1. Next cycle, if_pc=0x100 → if_pred_taken=1, target 0x80.
- Repeat with pred_taken=1 and pred_target=0x80 → redirect=0 and ctr reaches 2'b11. Then cmp=0 with pred_taken=1 → redirect_pc=0x104, ctr=2'b10, and if_pc=0x100 still predicts taken. A second not-taken drops ctr to 2'b01, and if_pc=0x100 then predicts not taken.
- Aliasing with ENTRIES=16: after 0x100 is trained taken, if_pc=0x140 → if_pred_taken=0 (same index, tag mismatch). A taken resolve at 0x140 replaces the entry, and 0x100 then misses.
- JALR target change: ex_jump=1, pred_taken=1, pred_target=0x200, ex_target=0x300 → redirect=1, redirect_pc=0x300, and the entry target becomes 0x300.
- Stall: a cold taken branch is held with ex_stall=1 for 3 cycles → redirect=0 and counters unchanged during the stall. When the stall drops → one redirect, branch_count +1. Asserting rst mid-sequence clears the trained entry at once.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch-side prediction and EX-side resolution signals between the pipeline and the predictor.
interface branch_predictor_if;
    // Fetch-stage lookup
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;

    // Execute-stage resolution
    logic        ex_valid;
    logic        ex_branch;
    logic        ex_jump;
    logic        ex_stall;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_cmp_result;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;

    // Control back to the pipeline
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush_if_id;
    logic        flush_id_ex;

    // Performance counters
    logic [31:0] mispredict_count;
    logic [31:0] branch_count;

    // Pipeline side
    modport master (
        output if_pc,
        output ex_valid, ex_branch, ex_jump, ex_stall, ex_pc, ex_target,
        output ex_cmp_result, ex_pred_taken, ex_pred_target,
        input  if_pred_taken, if_pred_target,
        input  redirect, redirect_pc, flush_if_id, flush_id_ex,
        input  mispredict_count, branch_count
    );

    // Predictor side
    modport slave (
        input  if_pc,
        input  ex_valid, ex_branch, ex_jump, ex_stall, ex_pc, ex_target,
        input  ex_cmp_result, ex_pred_taken, ex_pred_target,
        output if_pred_taken, if_pred_target,
        output redirect, redirect_pc, flush_if_id, flush_id_ex,
        output mispredict_count, branch_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target table with 2-bit saturating counters. Predicts for the IF PC,
// resolves branches/jumps in EX, drives redirect and flushes on a mispredict, and counts
// resolved branches and mispredicts.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic         clk,
    input  logic         rst,
    branch_predictor_if.slave bus
);
    localparam int unsigned IDX  = $clog2(ENTRIES);
    localparam int unsigned TAGW = 32 - IDX - 2;

    typedef logic [IDX-1:0]  idx_t;
    typedef logic [TAGW-1:0] tag_t;

    // Table storage
    logic [ENTRIES-1:0] valid_q;
    tag_t               tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [ENTRIES-1:0] jmp_q;
    logic [1:0]         ctr_q    [ENTRIES];

    logic [31:0] mis_cnt_q, mis_cnt_d;
    logic [31:0] br_cnt_q, br_cnt_d;

    // Lookup fields
    idx_t if_idx, ex_idx;
    tag_t if_tag, ex_tag;
    logic if_hit, ex_hit;
    logic pred_taken;

    // Resolution
    logic        res;
    logic        actual;
    logic        mis;
    logic [31:0] fallthrough_pc;

    // Update of the entry addressed by ex_pc
    logic        upd_en;
    logic [31:0] upd_target;
    logic        upd_jmp;
    logic [1:0]  upd_ctr;

    // Word-offset bits of the fetch PC never index or tag the table
    logic unused_if_pc_lsb;
    assign unused_if_pc_lsb = ^bus.if_pc[1:0];

    assign if_idx = bus.if_pc[IDX+1:2];
    assign if_tag = bus.if_pc[31:IDX+2];
    assign ex_idx = bus.ex_pc[IDX+1:2];
    assign ex_tag = bus.ex_pc[31:IDX+2];

    // Fetch-side prediction; reads the pre-update table, so a same-cycle EX write is not seen
    always_comb begin
        if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken = if_hit && (jmp_q[if_idx] || ctr_q[if_idx][1]);
    end

    assign bus.if_pred_taken  = pred_taken;
    assign bus.if_pred_target = pred_taken ? target_q[if_idx] : 32'd0;

    // EX-side resolution and mispredict detection; reset masks the redirect path
    always_comb begin
        res    = bus.ex_valid && !bus.ex_stall && (bus.ex_branch || bus.ex_jump);
        actual = bus.ex_jump || (bus.ex_branch && bus.ex_cmp_result);
        mis    = !rst && res &&
                 ((actual != bus.ex_pred_taken) ||
                  (actual && (bus.ex_pred_target != bus.ex_target)));
        fallthrough_pc = bus.ex_pc + 32'd4;
        ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    end

    assign bus.redirect    = mis;
    assign bus.flush_if_id = mis;
    assign bus.flush_id_ex = mis;
    assign bus.redirect_pc = !mis   ? 32'd0 :
                             actual ? bus.ex_target : fallthrough_pc;

    // Next-state of the entry at ex_idx: train on hit, allocate on taken miss
    always_comb begin
        upd_en     = 1'b0;
        upd_target = target_q[ex_idx];
        upd_jmp    = jmp_q[ex_idx];
        upd_ctr    = ctr_q[ex_idx];
        if (res) begin
            if (actual) begin
                upd_en     = 1'b1;
                upd_target = bus.ex_target;
                upd_jmp    = bus.ex_jump;
                if (ex_hit) begin
                    upd_ctr = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
                end else begin
                    upd_ctr = 2'b10;
                end
            end else if (ex_hit) begin
                upd_en  = 1'b1;
                upd_ctr = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
            end
        end
    end

    // Table write; async reset leaves every entry invalid and weakly not-taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            jmp_q   <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (upd_en) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= upd_target;
            jmp_q[ex_idx]    <= upd_jmp;
            ctr_q[ex_idx]    <= upd_ctr;
        end
    end

    // Performance counter next-state; both wrap naturally at 2^32
    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (res) begin
            br_cnt_d = br_cnt_q + 32'd1;
        end
        if (mis) begin
            mis_cnt_d = mis_cnt_q + 32'd1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign bus.branch_count     = br_cnt_q;
    assign bus.mispredict_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, stall/reset sequences and
// randomized traffic checked against an array-based reference model.
module tb_branch_predictor;
    localparam int unsigned ENTRIES = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_if bp_if ();

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bp_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one record per table slot, counters as plain integers 0..3
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    bit          m_jmp    [ENTRIES];
    int          m_ctr    [ENTRIES];
    logic [31:0] m_mis;
    logic [31:0] m_br;

    function automatic int unsigned m_index(input logic [31:0] pc);
        int unsigned p = pc;
        return (p / 4) % ENTRIES;
    endfunction

    function automatic int unsigned m_tagof(input logic [31:0] pc);
        int unsigned p = pc;
        return p / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int unsigned i = m_index(pc);
        return m_valid[i] && (m_tag[i] == m_tagof(pc));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = 32'd0;
            m_jmp[i]    = 1'b0;
            m_ctr[i]    = 1;
        end
        m_mis = 32'd0;
        m_br  = 32'd0;
    endtask

    task automatic m_predict(input logic [31:0] pc, output bit t, output logic [31:0] tgt);
        int unsigned i = m_index(pc);
        t   = m_hit(pc) && (m_jmp[i] || m_ctr[i] >= 2);
        tgt = t ? m_target[i] : 32'd0;
    endtask

    task automatic m_resolve(output bit res, output bit actual, output bit mis,
                             output logic [31:0] rpc);
        res    = bp_if.ex_valid && !bp_if.ex_stall && (bp_if.ex_branch || bp_if.ex_jump);
        actual = bp_if.ex_jump || (bp_if.ex_branch && bp_if.ex_cmp_result);
        mis    = !rst && res && ((actual != bp_if.ex_pred_taken) ||
                                 (actual && bp_if.ex_pred_target != bp_if.ex_target));
        if (!mis)        rpc = 32'd0;
        else if (actual) rpc = bp_if.ex_target;
        else             rpc = bp_if.ex_pc + 32'd4;
    endtask

    // Apply the EX-stage effect of the current inputs, as the clock edge will
    task automatic m_apply();
        bit res, actual, mis;
        logic [31:0] rpc;
        int unsigned i;
        bit hit;
        m_resolve(res, actual, mis, rpc);
        if (rst || !res) return;
        i   = m_index(bp_if.ex_pc);
        hit = m_hit(bp_if.ex_pc);
        m_br = m_br + 32'd1;
        if (mis) m_mis = m_mis + 32'd1;
        if (actual) begin
            if (hit) begin
                m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
            end else begin
                m_valid[i] = 1'b1;
                m_tag[i]   = m_tagof(bp_if.ex_pc);
                m_ctr[i]   = 2;
            end
            m_target[i] = bp_if.ex_target;
            m_jmp[i]    = bp_if.ex_jump;
        end else if (hit) begin
            m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Compare every output against the model for the inputs currently driven
    task automatic check_all(input string ctx);
        bit t, res, actual, mis;
        logic [31:0] tgt, rpc;
        m_predict(bp_if.if_pc, t, tgt);
        m_resolve(res, actual, mis, rpc);
        check({ctx, ".pred_taken"},  32'(bp_if.if_pred_taken), 32'(t));
        check({ctx, ".pred_target"}, bp_if.if_pred_target, tgt);
        check({ctx, ".redirect"},    32'(bp_if.redirect), 32'(mis));
        check({ctx, ".flush_if_id"}, 32'(bp_if.flush_if_id), 32'(mis));
        check({ctx, ".flush_id_ex"}, 32'(bp_if.flush_id_ex), 32'(mis));
        check({ctx, ".redirect_pc"}, bp_if.redirect_pc, rpc);
        check({ctx, ".mis_count"},   bp_if.mispredict_count, m_mis);
        check({ctx, ".br_count"},    bp_if.branch_count, m_br);
    endtask

    task automatic cycle_end();
        m_apply();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] if_pc, input bit v, input bit br, input bit jp,
                         input bit st, input logic [31:0] pc, input logic [31:0] tgt,
                         input bit cmp, input bit pt, input logic [31:0] ptgt);
        bp_if.if_pc          = if_pc;
        bp_if.ex_valid       = v;
        bp_if.ex_branch      = br;
        bp_if.ex_jump        = jp;
        bp_if.ex_stall       = st;
        bp_if.ex_pc          = pc;
        bp_if.ex_target      = tgt;
        bp_if.ex_cmp_result  = cmp;
        bp_if.ex_pred_taken  = pt;
        bp_if.ex_pred_target = ptgt;
    endtask

    typedef struct {
        logic [31:0] if_pc;
        bit          v, br, jp;
        logic [31:0] pc, tgt;
        bit          cmp, pt;
        logic [31:0] ptgt;
        bit          e_pt;
        logic [31:0] e_ptgt;
        bit          e_red;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] if_pc, input bit v, input bit br, input bit jp,
                       input logic [31:0] pc, input logic [31:0] tgt, input bit cmp,
                       input bit pt, input logic [31:0] ptgt, input bit e_pt,
                       input logic [31:0] e_ptgt, input bit e_red, input logic [31:0] e_rpc);
        vec_t r;
        r.if_pc = if_pc; r.v = v; r.br = br; r.jp = jp; r.pc = pc; r.tgt = tgt;
        r.cmp = cmp; r.pt = pt; r.ptgt = ptgt;
        r.e_pt = e_pt; r.e_ptgt = e_ptgt; r.e_red = e_red; r.e_rpc = e_rpc;
        vecs.push_back(r);
    endtask

    function automatic logic [31:0] rnd_pc();
        int unsigned hi = $urandom_range(0, 2);
        int unsigned lo = $urandom_range(0, 7);
        if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
        return 32'h1000 + 32'(hi * 64) + 32'(lo * 4);
    endfunction

    function automatic logic [31:0] rnd_tgt();
        case ($urandom_range(0, 3))
            0:       return 32'h2000;
            1:       return 32'h2040;
            2:       return 32'h3000;
            default: return 32'h1004;
        endcase
    endfunction

    initial begin
        logic [31:0] br0, mis0;

        // Reset with a would-be mispredict driven in EX: nothing may leak out
        rst = 1'b1;
        m_reset();
        drive(32'h100, 1, 1, 0, 0, 32'h100, 32'h80, 1, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check("reset.redirect_held", 32'(bp_if.redirect), 32'd0);
        rst = 1'b0;
        drive(32'h100, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);

        // Directed vectors: if_pc, v,br,jp, pc,tgt,cmp,pt,ptgt -> pred_taken,pred_tgt,redir,rpc
        add(32'h100, 0,0,0, 32'h0,   32'h0,  0,0,32'h0,   0,32'h0,   0,32'h0);
        add(32'h100, 1,1,0, 32'h100, 32'h80, 1,0,32'h0,   0,32'h0,   1,32'h80);
        add(32'h100, 0,0,0, 32'h0,   32'h0,  0,0,32'h0,   1,32'h80,  0,32'h0);
        add(32'h100, 1,1,0, 32'h100, 32'h80, 1,1,32'h80,  1,32'h80,  0,32'h0);
        add(32'h100, 1,1,0, 32'h100, 32'h80, 0,1,32'h80,  1,32'h80,  1,32'h104);
        add(32'h100, 0,0,0, 32'h0,   32'h0,  0,0,32'h0,   1,32'h80,  0,32'h0);
        add(32'h100, 1,1,0, 32'h100, 32'h80, 0,1,32'h80,  1,32'h80,  1,32'h104);
        add(32'h100, 0,0,0, 32'h0,   32'h0,  0,0,32'h0,   0,32'h0,   0,32'h0);
        add(32'h140, 1,1,0, 32'h100, 32'h80, 1,0,32'h0,   0,32'h0,   1,32'h80);
        add(32'h100, 0,0,0, 32'h0,   32'h0,  0,0,32'h0,   1,32'h80,  0,32'h0);
        add(32'h140, 0,0,0, 32'h0,   32'h0,  0,0,32'h0,   0,32'h0,   0,32'h0);
        add(32'h140, 1,1,0, 32'h140, 32'h40, 1,0,32'h0,   0,32'h0,   1,32'h40);
        add(32'h100, 0,0,0, 32'h0,   32'h0,  0,0,32'h0,   0,32'h0,   0,32'h0);
        add(32'h140, 0,0,0, 32'h0,   32'h0,  0,0,32'h0,   1,32'h40,  0,32'h0);
        add(32'h208, 1,0,1, 32'h208, 32'h200,0,0,32'h0,   0,32'h0,   1,32'h200);
        add(32'h208, 0,0,0, 32'h0,   32'h0,  0,0,32'h0,   1,32'h200, 0,32'h0);
        add(32'h208, 1,0,1, 32'h208, 32'h300,0,1,32'h200, 1,32'h200, 1,32'h300);
        add(32'h208, 0,0,0, 32'h0,   32'h0,  0,0,32'h0,   1,32'h300, 0,32'h0);
        add(32'h30C, 1,1,0, 32'h30C, 32'h400,0,0,32'h0,   0,32'h0,   0,32'h0);
        add(32'h30C, 0,0,0, 32'h0,   32'h0,  0,0,32'h0,   0,32'h0,   0,32'h0);
        add(32'h0,   1,1,0, 32'hFFFF_FFFC, 32'h10, 0,1,32'h10, 0,32'h0, 1,32'h0);
        add(32'h208, 0,1,0, 32'h500, 32'h600,1,0,32'h0,   1,32'h300, 0,32'h0);
        add(32'h208, 1,0,1, 32'h208, 32'h300,0,1,32'h300, 1,32'h300, 0,32'h0);

        foreach (vecs[k]) begin
            string nm;
            nm = $sformatf("vec%0d", k);
            drive(vecs[k].if_pc, vecs[k].v, vecs[k].br, vecs[k].jp, 1'b0, vecs[k].pc,
                  vecs[k].tgt, vecs[k].cmp, vecs[k].pt, vecs[k].ptgt);
            #4;
            check({nm, ".pred_taken"},  32'(bp_if.if_pred_taken), 32'(vecs[k].e_pt));
            check({nm, ".pred_target"}, bp_if.if_pred_target, vecs[k].e_ptgt);
            check({nm, ".redirect"},    32'(bp_if.redirect), 32'(vecs[k].e_red));
            check({nm, ".flush_if_id"}, 32'(bp_if.flush_if_id), 32'(vecs[k].e_red));
            check({nm, ".flush_id_ex"}, 32'(bp_if.flush_id_ex), 32'(vecs[k].e_red));
            check({nm, ".redirect_pc"}, bp_if.redirect_pc, vecs[k].e_rpc);
            check_all({nm, ".model"});
            cycle_end();
        end
        drive(32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        #4;
        check("tbl.br_count",  bp_if.branch_count, 32'd11);
        check("tbl.mis_count", bp_if.mispredict_count, 32'd8);
        cycle_end();

        // Stalled cold taken branch: no effect until the stall drops, then exactly once
        br0  = m_br;
        mis0 = m_mis;
        drive(32'h404, 1, 1, 0, 1, 32'h404, 32'h500, 1, 0, 32'h0);
        for (int s = 0; s < 3; s++) begin
            #4;
            check($sformatf("stall%0d.redirect", s), 32'(bp_if.redirect), 32'd0);
            check($sformatf("stall%0d.br_count", s), bp_if.branch_count, br0);
            check($sformatf("stall%0d.mis_count", s), bp_if.mispredict_count, mis0);
            cycle_end();
        end
        bp_if.ex_stall = 1'b0;
        #4;
        check("unstall.redirect",    32'(bp_if.redirect), 32'd1);
        check("unstall.redirect_pc", bp_if.redirect_pc, 32'h500);
        cycle_end();
        bp_if.ex_valid = 1'b0;
        #4;
        check("unstall.br_count",  bp_if.branch_count, br0 + 32'd1);
        check("unstall.mis_count", bp_if.mispredict_count, mis0 + 32'd1);
        check("unstall.pred_taken",  32'(bp_if.if_pred_taken), 32'd1);
        check("unstall.pred_target", bp_if.if_pred_target, 32'h500);
        check_all("unstall");

        // Asynchronous reset mid-cycle with a mispredict present in EX
        drive(32'h404, 1, 1, 0, 0, 32'h404, 32'h700, 1, 0, 32'h0);
        rst = 1'b1;
        m_reset();
        #1;
        check("rst.pred_taken", 32'(bp_if.if_pred_taken), 32'd0);
        check("rst.pred_target", bp_if.if_pred_target, 32'd0);
        check("rst.redirect",   32'(bp_if.redirect), 32'd0);
        check("rst.br_count",   bp_if.branch_count, 32'd0);
        check("rst.mis_count",  bp_if.mispredict_count, 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        drive(32'h404, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        check("postrst.pred_taken", 32'(bp_if.if_pred_taken), 32'd0);
        check_all("postrst");

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            logic [31:0] pc, tg;
            bit t;
            int kind;
            pc   = rnd_pc();
            kind = int'($urandom_range(0, 2));
            m_predict(pc, t, tg);
            if ($urandom_range(0, 3) == 0) begin
                t  = 1'($urandom_range(0, 1));
                tg = rnd_tgt();
            end
            drive(($urandom_range(0, 3) == 0) ? pc : rnd_pc(),
                  $urandom_range(0, 7) != 0, kind == 0, kind == 1,
                  $urandom_range(0, 4) == 0, pc, rnd_tgt(),
                  1'($urandom_range(0, 1)), t, tg);
            #4;
            check_all($sformatf("rnd%0d", c));
            cycle_end();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
